// File: rtl/debug_dump_engine_pkg.sv
// Shared types and ASCII helpers for the debug dump engine.
// The CSUM state only exists when DUMP_CSUM_EN is defined.
package dump_pkg;

`ifdef DUMP_CSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_READ, ST_CAPT, ST_SEND, ST_NEXT, ST_FIN, ST_CSUM
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_READ, ST_CAPT, ST_SEND, ST_NEXT, ST_FIN
    } state_t;
`endif

    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_NL    = 8'h0A;
    localparam logic [7:0] ASCII_S     = 8'h53;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) hex_char = 8'h30 + {4'h0, nib};
        else             hex_char = 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/debug_dump_engine_if.sv
// Read-port and byte-stream bundle between the dump engine and its memory/sink.
interface debug_dump_engine_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output rd_en, rd_addr, tx_data, tx_valid, input rd_data, tx_ready);
    modport slave  (input rd_en, rd_addr, tx_data, tx_valid, output rd_data, tx_ready);
endinterface

// File: rtl/debug_dump_engine_line_formatter.sv
// Combinational line formatter: maps (address, data, index) to one ASCII byte.
// A checksum line replaces the address digits with a single 'S'.
module line_formatter
    import dump_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int AD     = 2,
    parameter int IDX_W  = 4
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic [IDX_W-1:0]  idx,
    input  logic              csum_line,
    output logic [7:0]        char_out,
    output logic              last
);
    localparam int DD = DATA_W / 4;

    logic [4*AD-1:0] addr_pad;
    logic [3:0]      nib;
    int              pre;
    int              pos;

    always_comb begin
        addr_pad = '0;
        addr_pad[ADDR_W-1:0] = addr;
        pre      = csum_line ? 1 : AD;
        pos      = int'(32'(idx));
        nib      = '0;
        char_out = ASCII_NL;
        last     = 1'b0;
        if (pos < pre) begin
            if (csum_line) begin
                char_out = ASCII_S;
            end else begin
                nib      = 4'(addr_pad >> (4 * (AD - 1 - pos)));
                char_out = hex_char(nib);
            end
        end else if (pos == pre) begin
            char_out = ASCII_COLON;
        end else if (pos == pre + 1) begin
            char_out = ASCII_SPACE;
        end else if (pos < pre + 2 + DD) begin
            // digit j = pos-pre-2, MSB first
            nib      = 4'(data >> (4 * (pre + 1 + DD - pos)));
            char_out = hex_char(nib);
        end else begin
            last = 1'b1;
        end
    end
endmodule

// File: rtl/debug_dump_engine.sv
// Reads a word range from a synchronous read port and streams it as ASCII hex lines.
// Define DUMP_CSUM_EN to append an XOR checksum line ("S: ...") after the data lines.
module debug_dump_engine
    import dump_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W:0]     word_count,
    output logic                busy,
    output logic                done,
    debug_dump_engine_if.master bus
);
    localparam int AD    = (ADDR_W + 3) / 4;
    localparam int L     = AD + 3 + DATA_W / 4;
    localparam int IDX_W = $clog2(L);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic [DATA_W-1:0] word;
    logic [IDX_W-1:0]  idx;
    logic              rd_en;
    logic              tx_valid;
    logic              csum_line;
    logic [7:0]        fmt_char;
    logic              fmt_last;

`ifdef DUMP_CSUM_EN
    logic [DATA_W-1:0] csum;
`else
    assign csum_line = 1'b0;
`endif

    line_formatter #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .AD    (AD),
        .IDX_W (IDX_W)
    ) u_fmt (
        .addr     (addr),
        .data     (word),
        .idx      (idx),
        .csum_line(csum_line),
        .char_out (fmt_char),
        .last     (fmt_last)
    );

    assign bus.rd_en    = rd_en;
    assign bus.rd_addr  = addr;
    assign bus.tx_valid = tx_valid;
    // Gated so tx_data reads 0 whenever nothing is offered, including reset.
    assign bus.tx_data  = tx_valid ? fmt_char : 8'h00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            tx_valid  <= 1'b0;
            addr      <= '0;
            remaining <= '0;
            word      <= '0;
            idx       <= '0;
`ifdef DUMP_CSUM_EN
            csum      <= '0;
            csum_line <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            addr      <= start_addr;
                            remaining <= word_count;
                            busy      <= 1'b1;
                            rd_en     <= 1'b1;
`ifdef DUMP_CSUM_EN
                            csum      <= '0;
`endif
                            state     <= ST_READ;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    rd_en <= 1'b0;
                    state <= ST_CAPT;
                end
                ST_CAPT: begin
                    word     <= bus.rd_data;
                    idx      <= '0;
                    tx_valid <= 1'b1;
`ifdef DUMP_CSUM_EN
                    csum     <= csum ^ bus.rd_data;
`endif
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (bus.tx_ready) begin
                        if (fmt_last) begin
                            tx_valid <= 1'b0;
                            state    <= ST_NEXT;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ST_NEXT: begin
                    addr      <= addr + ADDR_W'(1);
                    remaining <= remaining - (ADDR_W + 1)'(1);
                    if (remaining != (ADDR_W + 1)'(1)) begin
                        rd_en <= 1'b1;
                        state <= ST_READ;
                    end else begin
`ifdef DUMP_CSUM_EN
                        word      <= csum;
                        idx       <= '0;
                        csum_line <= 1'b1;
                        tx_valid  <= 1'b1;
                        state     <= ST_CSUM;
`else
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_FIN;
`endif
                    end
                end
`ifdef DUMP_CSUM_EN
                ST_CSUM: begin
                    if (bus.tx_ready) begin
                        if (fmt_last) begin
                            tx_valid  <= 1'b0;
                            csum_line <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_FIN;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
`endif
                // done/busy were registered on entry so they land in this cycle
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
